// File: rtl/led_shift_pkg.sv
`default_nettype none
// ============================================================================
// Package  : led_shift_pkg
// Brief    : Mode encoding and divider/counter sizing helpers for led_shift_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package led_shift_pkg;

    localparam logic [1:0] c_MODE_HOLD   = 2'd0;
    localparam logic [1:0] c_MODE_LEFT   = 2'd1;
    localparam logic [1:0] c_MODE_RIGHT  = 2'd2;
    localparam logic [1:0] c_MODE_BOUNCE = 2'd3;

    typedef enum logic [1:0] {
        MODE_HOLD   = c_MODE_HOLD,
        MODE_LEFT   = c_MODE_LEFT,
        MODE_RIGHT  = c_MODE_RIGHT,
        MODE_BOUNCE = c_MODE_BOUNCE
    } mode_t;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Two-flop synchroniser plus stability filter for an active-low key.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
    import led_shift_pkg::*;
#(
    parameter int DB_CYCLES = 500_000
)(
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int                c_CNT_W = cnt_width(DB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DB_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_diff;
    logic               w_accept;

    assign w_diff   = r_sync[1] ^ r_level;
    assign w_accept = w_diff && (r_cnt == c_LAST);

    // Any sample agreeing with the accepted level restarts the stability run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_key};
            if (!w_diff || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_accept) begin
                r_level <= r_sync[1];
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = w_accept & ~r_sync[1];
    assign o_release = w_accept &  r_sync[1];

endmodule
`default_nettype wire

// File: rtl/led_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_shift_ctrl
// Brief    : Tick-driven LED rotator whose direction is chosen by press length.
//            Define LED_SHIFT_BOUNCE_EN to add the ping-pong (BOUNCE) mode.
// Revision : 1.0 - initial release
// ============================================================================
module led_shift_ctrl
    import led_shift_pkg::*;
#(
    parameter int N_LED     = 8,
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1,
    parameter int DB_CYCLES = 500_000,
    parameter int SHORT_T   = 3,
    parameter int LONG_T    = 5
`ifdef LED_SHIFT_BOUNCE_EN
    ,
    parameter int BOUNCE_T  = 7
`endif
)(
    input  logic             CLOCK_50,
    input  logic             RST,
    input  logic             KEY,
    output logic [N_LED-1:0] LEDR,
    output logic [1:0]       MODE,
    output logic             TICK
);

    localparam int c_DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int c_DIV_W = cnt_width(c_DIV);
`ifdef LED_SHIFT_BOUNCE_EN
    localparam int c_SAT   = BOUNCE_T;
`else
    localparam int c_SAT   = LONG_T;
`endif
    localparam int c_DUR_W = cnt_width(c_SAT + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [N_LED-1:0]   c_LED_INIT = N_LED'(1);

    logic               w_level;
    logic               w_press;
    logic               w_release;
    logic               w_key_down;
    logic               w_sub_wrap;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_DIV_W-1:0] r_sub;
    logic               r_tick;
    logic [c_DUR_W-1:0] r_dur;
    logic [c_DUR_W-1:0] w_dur_nxt;
    mode_t              r_mode;
    mode_t              w_mode_nxt;
    mode_t              w_mode_rel;
    logic [N_LED-1:0]   r_led;
    logic [N_LED-1:0]   w_led_nxt;
`ifdef LED_SHIFT_BOUNCE_EN
    logic               r_dir_left;
    logic               w_dir_nxt;
`endif

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_key_debounce (
        .clk       (CLOCK_50),
        .rst       (RST),
        .i_key     (KEY),
        .o_level   (w_level),
        .o_press   (w_press),
        .o_release (w_release)
    );

    assign w_key_down = ~w_level;
    assign w_sub_wrap = (r_sub == c_DIV_LAST);
    // Duration as it stands after this edge, so a release sees the final unit.
    assign w_dur_nxt  = (w_key_down && w_sub_wrap && (r_dur != c_DUR_W'(c_SAT)))
                        ? r_dur + c_DUR_W'(1) : r_dur;

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
            r_sub     <= '0;
            r_dur     <= '0;
        end else begin
            r_tick    <= (r_div_cnt == c_DIV_LAST);
            r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + c_DIV_W'(1);
            if (w_press) begin
                r_sub <= '0;
                r_dur <= '0;
            end else if (w_key_down) begin
                r_sub <= w_sub_wrap ? '0 : r_sub + c_DIV_W'(1);
                r_dur <= w_dur_nxt;
            end
        end
    end

    always_comb begin
        w_mode_rel = MODE_HOLD;
        if (w_dur_nxt >= c_DUR_W'(SHORT_T)) w_mode_rel = MODE_LEFT;
        if (w_dur_nxt >= c_DUR_W'(LONG_T))  w_mode_rel = MODE_RIGHT;
`ifdef LED_SHIFT_BOUNCE_EN
        if (w_dur_nxt >= c_DUR_W'(BOUNCE_T)) w_mode_rel = MODE_BOUNCE;
`endif
        w_mode_nxt = w_release ? w_mode_rel : r_mode;
    end

    // The shift on a tick uses r_mode, so a simultaneous release only affects later ticks.
    always_comb begin
        w_led_nxt = r_led;
`ifdef LED_SHIFT_BOUNCE_EN
        w_dir_nxt = r_dir_left;
`endif
        if (r_tick) begin
            if (r_led == '0) begin
                w_led_nxt = c_LED_INIT;
            end else begin
                case (r_mode)
                    MODE_LEFT:  w_led_nxt = {r_led[N_LED-2:0], r_led[N_LED-1]};
                    MODE_RIGHT: w_led_nxt = {r_led[0], r_led[N_LED-1:1]};
`ifdef LED_SHIFT_BOUNCE_EN
                    MODE_BOUNCE: begin
                        if (r_dir_left && r_led[N_LED-1]) begin
                            w_dir_nxt = 1'b0;
                        end else if (!r_dir_left && r_led[0]) begin
                            w_dir_nxt = 1'b1;
                        end
                        w_led_nxt = w_dir_nxt ? (r_led << 1) : (r_led >> 1);
                    end
`endif
                    default: w_led_nxt = r_led;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_mode <= MODE_HOLD;
            r_led  <= c_LED_INIT;
        end else begin
            r_mode <= w_mode_nxt;
            r_led  <= w_led_nxt;
        end
    end

`ifdef LED_SHIFT_BOUNCE_EN
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_dir_left <= 1'b1;
        end else begin
            r_dir_left <= w_dir_nxt;
        end
    end
`endif

    assign LEDR = r_led;
    assign MODE = r_mode;
    assign TICK = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_shift_ctrl
// Brief    : Self-checking bench for led_shift_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_shift_ctrl;

    localparam int N       = 8;
    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int DB      = 4;
    localparam int SHORT_T = 3;
    localparam int LONG_T  = 5;
    localparam int DIV     = CLK_HZ / TICK_HZ;
`ifdef LED_SHIFT_BOUNCE_EN
    localparam int BOUNCE_T = 7;
    localparam int SAT      = BOUNCE_T;
`else
    localparam int SAT      = LONG_T;
`endif

    logic         CLOCK_50 = 1'b0;
    logic         RST      = 1'b1;
    logic         KEY      = 1'b1;
    logic [N-1:0] LEDR;
    logic [1:0]   MODE;
    logic         TICK;

    always #5 CLOCK_50 = ~CLOCK_50;

    led_shift_ctrl #(
        .N_LED     (N),
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .DB_CYCLES (DB),
        .SHORT_T   (SHORT_T),
        .LONG_T    (LONG_T)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .KEY      (KEY),
        .LEDR     (LEDR),
        .MODE     (MODE),
        .TICK     (TICK)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: edges since reset, raw key history, pattern as an integer.
    int cyc;
    bit m_tick;
    int m_led;
    int m_mode;
    bit m_level;
    int m_press;
    bit m_dir_left;
    bit hist [0:DB];

    function automatic int rotl(input int v);
        return (v * 2) % (1 << N) + v / (1 << (N - 1));
    endfunction

    function automatic int rotr(input int v);
        return v / 2 + (v % 2) * (1 << (N - 1));
    endfunction

    function automatic int decode(input int d);
`ifdef LED_SHIFT_BOUNCE_EN
        if (d >= BOUNCE_T) return 3;
`endif
        if (d >= LONG_T)  return 2;
        if (d >= SHORT_T) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        cyc = 0; m_tick = 0; m_led = 1; m_mode = 0;
        m_level = 1; m_press = 0; m_dir_left = 1;
        for (int i = 0; i <= DB; i++) hist[i] = 1'b1;
    endtask

    task automatic cycle();
        bit stable;
        int d;
        @(posedge CLOCK_50);
        cyc++;
        if (m_tick) begin
            if (m_led == 0) m_led = 1;
            else if (m_mode == 1) m_led = rotl(m_led);
            else if (m_mode == 2) m_led = rotr(m_led);
            else if (m_mode == 3) begin
                if (m_dir_left && m_led == (1 << (N - 1))) m_dir_left = 0;
                else if (!m_dir_left && m_led == 1) m_dir_left = 1;
                m_led = m_dir_left ? m_led * 2 : m_led / 2;
            end
        end
        m_tick = (cyc % DIV == 0);
        // Synchronised sample at this edge is the key from two edges back.
        stable = 1;
        for (int i = 1; i <= DB; i++) if (hist[i] == m_level) stable = 0;
        if (stable) begin
            m_level = !m_level;
            if (!m_level) m_press = cyc;
            else begin
                d = (cyc - m_press) / DIV;
                if (d > SAT) d = SAT;
                m_mode = decode(d);
            end
        end
        for (int i = DB; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = KEY;
        #2;
    endtask

    task automatic test_reset();
        RST = 1'b1; KEY = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #2;
        n_checks++; if (LEDR !== 8'h01) $display("FAIL reset_led: got %h expected 01", LEDR); else n_pass++;
        n_checks++; if (MODE !== 2'd0) $display("FAIL reset_mode: got %0d expected 0", MODE); else n_pass++;
        n_checks++; if (TICK !== 1'b0) $display("FAIL reset_tick: got %b expected 0", TICK); else n_pass++;
        RST = 1'b0;
        model_reset();
        repeat (DIV - 1) cycle();
        n_checks++; if (TICK !== 1'b0) $display("FAIL tick_early: got %b expected 0 at cycle %0d", TICK, cyc); else n_pass++;
        cycle();
        n_checks++; if (TICK !== 1'b1) $display("FAIL first_tick: got %b expected 1 at cycle %0d", TICK, cyc); else n_pass++;
        cycle();
        n_checks++; if (TICK !== 1'b0) $display("FAIL tick_width: got %b expected 0", TICK); else n_pass++;
        repeat (5 * DIV) cycle();
        n_checks++; if (LEDR !== 8'h01) $display("FAIL hold_5ticks: got %h expected 01", LEDR); else n_pass++;
    endtask

    task automatic test_left();
        int exp;
        KEY = 1'b0; repeat (35) cycle();
        KEY = 1'b1; repeat (DB + 2) cycle();
        n_checks++; if (MODE !== 2'd1) $display("FAIL left_mode: got %0d expected 1", MODE); else n_pass++;
        n_checks++; if (LEDR !== 8'h01) $display("FAIL left_start: got %h expected 01", LEDR); else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            do cycle(); while (cyc % DIV != 1);
            exp = 1 << (k % 8);
            n_checks++; if (LEDR !== N'(exp)) $display("FAIL left_step%0d: got %h expected %h", k, LEDR, N'(exp)); else n_pass++;
        end
    endtask

    task automatic test_right();
        KEY = 1'b0; repeat (60) cycle();
        KEY = 1'b1; repeat (DB + 2) cycle();
        n_checks++; if (MODE !== 2'd2) $display("FAIL right_mode: got %0d expected 2", MODE); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            do cycle(); while (cyc % DIV != 1);
            n_checks++; if (LEDR !== N'(m_led)) $display("FAIL right_step%0d: got %h expected %h", k, LEDR, N'(m_led)); else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int frozen;
        for (int g = 0; g < 4; g++) begin
            KEY = 1'b0; repeat (2) cycle();
            KEY = 1'b1; repeat (6) cycle();
        end
        n_checks++; if (MODE !== 2'd2) $display("FAIL glitch_mode: got %0d expected 2", MODE); else n_pass++;
        n_checks++; if (LEDR !== N'(m_led)) $display("FAIL glitch_led: got %h expected %h", LEDR, N'(m_led)); else n_pass++;
        // 15-cycle press with a short bounce inside it
        KEY = 1'b0; repeat (7) cycle();
        KEY = 1'b1; repeat (2) cycle();
        KEY = 1'b0; repeat (6) cycle();
        KEY = 1'b1; repeat (DB + 2) cycle();
        n_checks++; if (MODE !== 2'd0) $display("FAIL short_mode: got %0d expected 0", MODE); else n_pass++;
        cycle();
        frozen = m_led;
        repeat (3 * DIV) cycle();
        n_checks++; if (LEDR !== N'(frozen)) $display("FAIL hold_frozen: got %h expected %h", LEDR, N'(frozen)); else n_pass++;
    endtask

    task automatic test_release_on_tick();
        int prev;
        KEY = 1'b0; repeat (35) cycle();
        KEY = 1'b1; repeat (DB + 2) cycle();
        n_checks++; if (MODE !== 2'd1) $display("FAIL rot_pre_mode: got %0d expected 1", MODE); else n_pass++;
        KEY = 1'b0; repeat (55) cycle();
        while ((cyc + 1 + DB) % DIV != 0) cycle();
        KEY = 1'b1;
        repeat (1 + DB) cycle();
        prev = m_led;
        n_checks++; if (TICK !== 1'b1) $display("FAIL rot_tick: got %b expected 1", TICK); else n_pass++;
        cycle();
        n_checks++; if (MODE !== 2'd2) $display("FAIL rot_mode: got %0d expected 2", MODE); else n_pass++;
        n_checks++; if (LEDR !== N'(rotl(prev))) $display("FAIL rot_old_dir: got %h expected %h", LEDR, N'(rotl(prev))); else n_pass++;
        do cycle(); while (cyc % DIV != 1);
        n_checks++; if (LEDR !== N'(prev)) $display("FAIL rot_new_dir: got %h expected %h", LEDR, N'(prev)); else n_pass++;
    endtask

    task automatic test_reset_mid_press();
        KEY = 1'b0; repeat (30) cycle();
        RST = 1'b1;
        #1;
        n_checks++; if (LEDR !== 8'h01) $display("FAIL rstmid_led: got %h expected 01", LEDR); else n_pass++;
        n_checks++; if (MODE !== 2'd0) $display("FAIL rstmid_mode: got %0d expected 0", MODE); else n_pass++;
        n_checks++; if (TICK !== 1'b0) $display("FAIL rstmid_tick: got %b expected 0", TICK); else n_pass++;
        KEY = 1'b1;
        @(posedge CLOCK_50);
        #2;
        RST = 1'b0;
        model_reset();
        repeat (40) cycle();
        n_checks++; if (MODE !== 2'd0) $display("FAIL rstmid_release: got %0d expected 0", MODE); else n_pass++;
        n_checks++; if (LEDR !== 8'h01) $display("FAIL rstmid_hold: got %h expected 01", LEDR); else n_pass++;
    endtask

`ifdef LED_SHIFT_BOUNCE_EN
    task automatic test_bounce();
        int p;
        KEY = 1'b0; repeat (75) cycle();
        KEY = 1'b1; repeat (DB + 2) cycle();
        n_checks++; if (MODE !== 2'd3) $display("FAIL bounce_mode: got %0d expected 3", MODE); else n_pass++;
        for (int k = 1; k <= 16; k++) begin
            do cycle(); while (cyc % DIV != 1);
            p = k % 14;
            if (p > 7) p = 14 - p;
            n_checks++; if (LEDR !== N'(1 << p)) $display("FAIL bounce_step%0d: got %h expected %h", k, LEDR, N'(1 << p)); else n_pass++;
        end
    endtask
`endif

    task automatic test_random();
        int len;
        for (int r = 0; r < 60; r++) begin
            KEY = ~KEY;
            len = (r % 3 == 0) ? $urandom_range(1, DB - 1) : $urandom_range(DB, 80);
            for (int i = 0; i < len; i++) begin
                cycle();
                n_checks++; if (LEDR !== N'(m_led)) $display("FAIL rand_led: got %h expected %h at cycle %0d", LEDR, N'(m_led), cyc); else n_pass++;
                n_checks++; if (MODE !== 2'(m_mode)) $display("FAIL rand_mode: got %0d expected %0d at cycle %0d", MODE, m_mode, cyc); else n_pass++;
                n_checks++; if (TICK !== m_tick) $display("FAIL rand_tick: got %b expected %b at cycle %0d", TICK, m_tick, cyc); else n_pass++;
            end
        end
        KEY = 1'b1;
        repeat (DB + 3) cycle();
        n_checks++; if (MODE !== 2'(m_mode)) $display("FAIL rand_final_mode: got %0d expected %0d", MODE, m_mode); else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_left();
        test_right();
        test_glitch();
        test_release_on_tick();
        test_reset_mid_press();
`ifdef LED_SHIFT_BOUNCE_EN
        test_bounce();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
